// File: rtl/mbyte_add_seq_pkg.sv
// Shared definitions for the byte-serial multi-byte adder: FSM state encodings,
// the byte width and a ceiling-log2 helper used to size the byte index.
package mbyte_add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mbyte_add_seq_csa_8.sv
// csa_8: 8-bit carry-select adder. The low nibble ripples, and the high nibble is
// precomputed for both carry values and selected by the low nibble's carry-out.
module csa_8
    import mbyte_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    localparam int NIB = BYTE_W / 2;

    logic [NIB:0] lo_sum;
    logic [NIB:0] hi_sum0;
    logic [NIB:0] hi_sum1;

    assign lo_sum  = {1'b0, a[NIB-1:0]} + {1'b0, b[NIB-1:0]} + {{NIB{1'b0}}, cin};
    assign hi_sum0 = {1'b0, a[BYTE_W-1:NIB]} + {1'b0, b[BYTE_W-1:NIB]};
    assign hi_sum1 = {1'b0, a[BYTE_W-1:NIB]} + {1'b0, b[BYTE_W-1:NIB]} + {{NIB{1'b0}}, 1'b1};

    assign sum  = {(lo_sum[NIB] ? hi_sum1[NIB-1:0] : hi_sum0[NIB-1:0]), lo_sum[NIB-1:0]};
    assign cout = lo_sum[NIB] ? hi_sum1[NIB] : hi_sum0[NIB];

endmodule

// File: rtl/mbyte_add_seq.sv
// Byte-serial NBYTES-wide adder: captures operands on START, adds one byte per
// clock through csa_8, LSB first. Define MBYTE_ADD_OVF_EN to add the OVF output.
module mbyte_add_seq
    import mbyte_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
)
(
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [BYTE_W*NBYTES-1:0] A,
    input  logic [BYTE_W*NBYTES-1:0] B,
    input  logic                     CIN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [BYTE_W*NBYTES-1:0] SUM,
    output logic                     COUT
`ifdef MBYTE_ADD_OVF_EN
   ,output logic                     OVF
`endif
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  byte_sum;
    logic               byte_cout;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // START is only honoured in IDLE, so requests during RUN or FIN are dropped.
    always_comb begin
        next_state = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = ST_FIN;
                end
            end
            ST_FIN: begin
                DONE       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                a_byte = a_reg[i*BYTE_W +: BYTE_W];
                b_byte = b_reg[i*BYTE_W +: BYTE_W];
            end
        end
    end

    csa_8 u_csa_8 (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    // SUM/COUT are deliberately left alone on START so the last result stays visible.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= CIN;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            SUM[i*BYTE_W +: BYTE_W] <= byte_sum;
                        end
                    end
                    carry <= byte_cout;
                    if (idx == LAST_IDX) begin
                        COUT <= byte_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MBYTE_ADD_OVF_EN
    // Carry into the top bit is recovered from the top byte's operand and sum MSBs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF <= 1'b0;
        end else if (state == ST_RUN && idx == LAST_IDX) begin
            OVF <= (a_byte[BYTE_W-1] ^ b_byte[BYTE_W-1] ^ byte_sum[BYTE_W-1]) ^ byte_cout;
        end
    end
`endif

endmodule
